// File: rtl/nibble_add_sched.sv
// nibble_add_sched: two-client round-robin scheduler around a shared 4-bit
// adder slice. Each accepted request is added nibble-serially, LSB nibble
// first, with the carry held in a register between nibbles. The result is
// returned on a valid/ready channel tagged with the requesting client id.
module nibble_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             last_grant_r;

  logic             grant_vld_s;
  logic             grant_id_s;
  logic             accept_s;
  logic             last_nib_s;
  logic             rsp_hs_s;
  logic [4:0]       slice_s;

  // The shared 4-bit slice: {carry_out, sum_nibble}.
  function automatic logic [4:0] nibble_add(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       c);
    nibble_add = {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

  // Round-robin grant: sole valid client wins, on contention the client
  // that was not granted last time wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ~last_grant_r;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  assign accept_s   = (state_r == IDLE) && grant_vld_s;
  assign req0_ready = accept_s && !grant_id_s;
  assign req1_ready = accept_s && grant_id_s;
  assign last_nib_s = (cnt_r == CW'(NIB - 1));
  assign rsp_hs_s   = rsp_valid && rsp_ready;
  // Operands shift right every ADD cycle, so the current nibble is always [3:0].
  assign slice_s    = nibble_add(a_r[3:0], b_r[3:0], carry_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: IDLE -> ADD on accept, ADD -> RESP after the last
  // nibble, RESP -> IDLE on the response handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = ADD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ADD: begin
        if (last_nib_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = ADD;
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs: latch the granted request, run the
  // slice one nibble per cycle, hold the response until it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r          <= '0;
      b_r          <= '0;
      carry_r      <= 1'b0;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r          <= grant_id_s ? req1_a   : req0_a;
            b_r          <= grant_id_s ? req1_b   : req0_b;
            carry_r      <= grant_id_s ? req1_cin : req0_cin;
            cnt_r        <= '0;
            last_grant_r <= grant_id_s;
            rsp_id       <= grant_id_s;
            busy         <= 1'b1;
          end
        end
        ADD: begin
          a_r     <= a_r >> 3'd4;
          b_r     <= b_r >> 3'd4;
          carry_r <= slice_s[4];
          cnt_r   <= cnt_r + CW'(1);
          // New nibble enters at the top; after NIB cycles nibble 0 sits at [3:0].
          rsp_sum <= (rsp_sum >> 3'd4) | (WIDTH'(slice_s[3:0]) << (WIDTH - 4));
          if (last_nib_s) begin
            rsp_cout  <= slice_s[4];
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs_s) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Testbench for nibble_add_sched: directed vectors, expected responses
// queued at issue time and checked by independent monitors at handshake.
module tb_nibble_add_sched;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  logic         n4_req0_valid, n4_req0_ready, n4_req0_cin;
  logic [3:0]   n4_req0_a, n4_req0_b;
  logic         n4_req1_valid, n4_req1_ready, n4_req1_cin;
  logic [3:0]   n4_req1_a, n4_req1_b;
  logic         n4_rsp_valid, n4_rsp_ready, n4_rsp_id, n4_rsp_cout, n4_busy;
  logic [3:0]   n4_rsp_sum;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  int   acc_q[$];
  int   acc4_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc4_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev4_valid = 1'b0;

  nibble_add_sched #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  nibble_add_sched #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(n4_req0_valid), .req0_ready(n4_req0_ready), .req0_a(n4_req0_a),
    .req0_b(n4_req0_b), .req0_cin(n4_req0_cin),
    .req1_valid(n4_req1_valid), .req1_ready(n4_req1_ready), .req1_a(n4_req1_a),
    .req1_b(n4_req1_b), .req1_cin(n4_req1_cin),
    .rsp_valid(n4_rsp_valid), .rsp_ready(n4_rsp_ready), .rsp_id(n4_rsp_id),
    .rsp_sum(n4_rsp_sum), .rsp_cout(n4_rsp_cout), .busy(n4_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance watcher: records the edge at which each request is taken.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_q.push_back(cyc + 1);
        acc_cnt++;
      end
      if (n4_req0_valid && n4_req0_ready) begin
        acc4_q.push_back(cyc + 1);
        acc4_cnt++;
      end
    end
  end

  // Response monitor for the 16-bit instance.
  always @(negedge clk) begin : mon16
    exp_t e;
    int   a;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail("latency_no_accept");
        else begin
          a = acc_q.pop_front();
          check("latency", cyc - a, 32'd4);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          check("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
          check("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
        end
      end
      prev_valid <= rsp_valid;
    end
  end

  // Response monitor for the 4-bit instance.
  always @(negedge clk) begin : mon4
    exp_t e;
    int   a;
    if (rst) begin
      prev4_valid <= 1'b0;
    end else begin
      if (n4_rsp_valid && !prev4_valid) begin
        if (acc4_q.size() == 0) fail("w4_latency_no_accept");
        else begin
          a = acc4_q.pop_front();
          check("w4_latency", cyc - a, 32'd1);
        end
      end
      if (n4_rsp_valid && n4_rsp_ready) begin
        if (exp4_q.size() == 0) fail("w4_unexpected_rsp");
        else begin
          e = exp4_q.pop_front();
          check("w4_rsp_id", {31'd0, n4_rsp_id}, {31'd0, e.id});
          check("w4_rsp_sum", {28'd0, n4_rsp_sum}, {28'd0, e.sum[3:0]});
          check("w4_rsp_cout", {31'd0, n4_rsp_cout}, {31'd0, e.cout});
        end
      end
      prev4_valid <= n4_rsp_valid;
    end
  end

  // Wait (bounded) until the acceptance count reaches target; returns #1 after the accepting edge.
  task automatic wait_acc(input int target, input bit w4);
    for (int i = 0; i < 200 && (w4 ? acc4_cnt : acc_cnt) < target; i++) @(posedge clk);
    #1;
    if ((w4 ? acc4_cnt : acc_cnt) < target) fail(w4 ? "w4_accept_timeout" : "accept_timeout");
  endtask

  // Wait (bounded) until every queued expectation has been consumed.
  task automatic wait_empty(input bit w4);
    for (int i = 0; i < 200 && (w4 ? exp4_q.size() : exp_q.size()) != 0; i++) @(posedge clk);
    #1;
    if ((w4 ? exp4_q.size() : exp_q.size()) != 0) begin
      fail(w4 ? "w4_response_timeout" : "response_timeout");
      exp_q.delete();
      exp4_q.delete();
    end
  endtask

  task automatic issue0(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] s, input logic co);
    exp_q.push_back('{id: 1'b0, sum: s, cout: co});
    req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    wait_acc(acc_cnt + 1, 1'b0);
    req0_valid = 1'b0;
    req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_cin = ~cin;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    n4_req0_valid = 1'b0; n4_req0_a = 4'h0; n4_req0_b = 4'h0; n4_req0_cin = 1'b0;
    n4_req1_valid = 1'b0; n4_req1_a = 4'h0; n4_req1_b = 4'h0; n4_req1_cin = 1'b0;
    n4_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_sum", {16'd0, rsp_sum}, 32'd0);
    check("rst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);

    // Both clients valid from reset: grants 0,1,0,1.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{id: i[0], sum: 16'h0100, cout: 1'b0});
    req0_a = 16'h00FF; req0_b = 16'h0000; req0_cin = 1'b1;
    req1_a = 16'h00FF; req1_b = 16'h0000; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(acc_cnt + 4, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_empty(1'b0);

    // Basic add; operands altered after accept must not matter.
    issue0(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    @(negedge clk);
    check("busy_in_add", {31'd0, busy}, 32'd1);
    check("req0_ready_in_add", {31'd0, req0_ready}, 32'd0);
    wait_empty(1'b0);

    // Carry ripples through every nibble into cout.
    issue0(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    wait_empty(1'b0);

    // Response back-pressure: outputs hold, no request accepted meanwhile.
    rsp_ready = 1'b0;
    issue0(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);
    n = acc_cnt;
    exp_q.push_back('{id: 1'b1, sum: 16'h0001, cout: 1'b1});
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_sum", {16'd0, rsp_sum}, 32'h1010);
      check("stall_id", {31'd0, rsp_id}, 32'd0);
      check("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("stall_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_acc(n + 1, 1'b0);
    req1_valid = 1'b0;
    wait_empty(1'b0);

    // Reset in the middle of an addition aborts it.
    req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    wait_acc(acc_cnt + 1, 1'b0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back('{id: 1'b0, sum: 16'h3333, cout: 1'b0});
    exp_q.push_back('{id: 1'b1, sum: 16'h1000, cout: 1'b1});
    req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    req1_a = 16'hA000; req1_b = 16'h7000; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(acc_cnt + 2, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_empty(1'b0);

    // WIDTH=4 instance: single-nibble operations.
    exp4_q.push_back('{id: 1'b0, sum: 16'h000F, cout: 1'b1});
    n4_req0_a = 4'hF; n4_req0_b = 4'hF; n4_req0_cin = 1'b1; n4_req0_valid = 1'b1;
    wait_acc(acc4_cnt + 1, 1'b1);
    n4_req0_valid = 1'b0;
    wait_empty(1'b1);
    exp4_q.push_back('{id: 1'b0, sum: 16'h000F, cout: 1'b0});
    n4_req0_a = 4'h7; n4_req0_b = 4'h8; n4_req0_cin = 1'b0; n4_req0_valid = 1'b1;
    wait_acc(acc4_cnt + 1, 1'b1);
    n4_req0_valid = 1'b0;
    wait_empty(1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
